branch_predictor: RTL

Next-PC generator for the fetch stage: a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. It looks up the PC currently held in the PC register and drives the predicted next PC back into it. It is trained by EX branch resolutions, the same path that carries the EX redirect flag/target. Lookup is combinational on registered tables; training is synchronous.

---
 rtl/branch_predictor.sv | 88 ++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB next-PC predictor with optional 2-bit counters
// Define BP_COUNTER_EN for per-entry saturating counters; otherwise every BTB hit predicts taken.
module branch_predictor #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pred_pc_o,
  output logic              pred_taken_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
`ifdef BP_COUNTER_EN
  logic [1:0]         ctr_q    [ENTRIES];
`endif

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;
  logic                  unused_pc_lsbs;

  assign lk_idx  = pc_i[INDEX_BITS+1:2];
  assign lk_tag  = pc_i[ADDR_W-1:INDEX_BITS+2];
  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_idx = upd_pc_i[INDEX_BITS+1:2];
  assign upd_tag = upd_pc_i[ADDR_W-1:INDEX_BITS+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign unused_pc_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};

  always_comb begin
`ifdef BP_COUNTER_EN
    pred_taken_o = lk_hit && ctr_q[lk_idx][1];
`else
    pred_taken_o = lk_hit;
`endif
    pred_pc_o = pred_taken_o ? target_q[lk_idx] : pc_i + ADDR_W'(4);
  end

  // Valid bits and counters are the only state that reset must define.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
`ifdef BP_COUNTER_EN
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
`endif
    end else if (upd_valid_i) begin
      if (upd_hit) begin
`ifdef BP_COUNTER_EN
        if (upd_taken_i) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
        end else begin
          if (ctr_q[upd_idx] != 2'b00) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
        end
`else
        if (!upd_taken_i) valid_q[upd_idx] <= 1'b0;
`endif
      end else if (upd_taken_i) begin
        valid_q[upd_idx] <= 1'b1;
`ifdef BP_COUNTER_EN
        ctr_q[upd_idx]   <= 2'b10;
`endif
      end
    end
  end

  // Any taken resolution writes tag and target: a hit rewrites the same tag, a miss allocates.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid_i && upd_taken_i) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target_i;
    end
  end

endmodule
